// File: rtl/dmem_lsu.sv
// Load/store initiator between the core memory stage and a word-indexed dmem.
// Latency: response 1 (error), 2 (store), 3 (split store / load), 4 (split load) cycles after accept.
// Backpressure: one request at a time; req_ready only in IDLE; rsp_valid is a 1-cycle pulse that cannot stall.
module dmem_lsu #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, RDATA, RESP} state_t;
    state_t state;

    // Request fields latched at acceptance
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic        r_split;
    logic [63:0] r_wd64;
    logic [7:0]  r_m8;
    logic [31:0] w0;

    // Decode of the incoming request
    logic [1:0]  in_off;
    logic [2:0]  in_n;
    logic        in_split;
    logic [31:0] in_wdat;
    logic [63:0] in_wd64;
    logic [7:0]  in_m8;
    logic [31:0] in_end;
    logic        in_err;

    // Load assembly from the captured words
    logic [31:0] lw0;
    logic [31:0] lw1;
    logic [63:0] lsh;
    logic [31:0] ld;

    assign req_ready = (state == IDLE) && !rst;

    // Size/offset decode, lane placement and range check for the request at the port
    always_comb begin
        in_off = req_addr[1:0];
        case (req_size)
            2'b00:   in_n = 3'd1;
            2'b01:   in_n = 3'd2;
            default: in_n = 3'd4;
        endcase
        in_split = ({1'b0, in_off} + in_n) > 3'd4;
        case (req_size)
            2'b00:   in_wdat = {24'd0, req_wdata[7:0]};
            2'b01:   in_wdat = {16'd0, req_wdata[15:0]};
            default: in_wdat = req_wdata;
        endcase
        in_wd64 = {32'd0, in_wdat} << {in_off, 3'b000};
        in_m8   = ((8'd1 << in_n) - 8'd1) << in_off;
        in_end  = {2'b00, req_addr[31:2]} + {31'd0, in_split};
        in_err  = (req_size == 2'b11) || (in_end >= MEM_WORDS);
    end

    // Shift the {w1, w0} window down to the addressed bytes and extend
    always_comb begin
        lw0 = r_split ? w0 : mem_rdata;
        lw1 = r_split ? mem_rdata : 32'd0;
        lsh = {lw1, lw0} >> {r_off, 3'b000};
        case (r_size)
            2'b00:   ld = r_uns ? {24'd0, lsh[7:0]}  : {{24{lsh[7]}}, lsh[7:0]};
            2'b01:   ld = r_uns ? {16'd0, lsh[15:0]} : {{16{lsh[15]}}, lsh[15:0]};
            default: ld = lsh[31:0];
        endcase
    end

    // Control FSM; every memory-port and response output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_off     <= 2'd0;
            r_split   <= 1'b0;
            r_wd64    <= 64'd0;
            r_m8      <= 8'd0;
            w0        <= 32'd0;
        end else begin
            // The pulse follows the RESP state by one cycle, so it lands with req_ready
            rsp_valid <= (state == RESP);
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we      <= req_we;
                        r_size    <= req_size;
                        r_uns     <= req_unsigned;
                        r_off     <= in_off;
                        r_split   <= in_split;
                        r_wd64    <= in_wd64;
                        r_m8      <= in_m8;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= in_err;
                        if (in_err) begin
                            state <= RESP;
                        end else begin
                            state     <= ACC0;
                            mem_addr  <= {2'b00, req_addr[31:2]};
                            mem_wdata <= in_wd64[31:0];
                            mem_wmask <= req_we ? in_m8[3:0] : 4'd0;
                            mem_we    <= req_we;
                        end
                    end
                end
                ACC0: begin
                    if (r_split) begin
                        state     <= ACC1;
                        mem_addr  <= mem_addr + 32'd1;
                        mem_wdata <= r_wd64[63:32];
                        mem_wmask <= r_we ? r_m8[7:4] : 4'd0;
                        mem_we    <= r_we;
                    end else begin
                        mem_we    <= 1'b0;
                        mem_wmask <= 4'd0;
                        state     <= r_we ? RESP : RDATA;
                    end
                end
                ACC1: begin
                    // Read data of access 0 arrives during this cycle
                    w0        <= mem_rdata;
                    mem_we    <= 1'b0;
                    mem_wmask <= 4'd0;
                    state     <= r_we ? RESP : RDATA;
                end
                RDATA: begin
                    rsp_rdata <= ld;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural synchronous-read dmem.
// Latency: checked per request as the cycle index of rsp_valid after the accept edge.
// Backpressure: requests issued only from IDLE; back-to-back case holds req_valid high.
module tb_dmem_lsu;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // Behavioural dmem: byte-masked write and registered read on the same edge
    logic [31:0] mem [0:MEM_SIZE-1];
    always @(posedge clk) begin
        if (mem_addr < 32'(MEM_SIZE)) begin
            mem_rdata <= mem[int'(mem_addr)];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem[int'(mem_addr)][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
            mem_rdata <= 32'd0;
        end
    end

    // Per-request observation, indexed by cycle after the accept edge
    int          lat;
    int          rsp_cnt;
    int          we_cycles;
    logic        issue_rdy;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] tr_addr  [8];
    logic [31:0] tr_wdata [8];
    logic [3:0]  tr_mask  [8];
    logic        tr_we    [8];
    logic        tr_rdy   [8];

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        #1 issue_rdy = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rsp_cnt = 0; we_cycles = 0; got_rdata = 'x; got_err = 1'bx;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tr_addr[c] = mem_addr; tr_wdata[c] = mem_wdata; tr_mask[c] = mem_wmask;
            tr_we[c] = mem_we; tr_rdy[c] = req_ready;
            if (mem_we) we_cycles++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (lat < 0) begin lat = c; got_rdata = rsp_rdata; got_err = rsp_err; end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got %b exp 0", req_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
        checks++; if ({rsp_valid, rsp_err, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {rsp_valid, rsp_err, mem_we}); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
        checks++; if (mem_wmask !== 4'd0) begin errors++; $display("FAIL rst_wmask got %b exp 0000", mem_wmask); end
        checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin errors++; $display("FAIL rst_addr_wdata got %h exp 0", {mem_addr, mem_wdata}); end
    endtask

    task automatic test_word;
        mem[4] = 32'hFFFF_FFFF;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL wst_ready got %b exp 1", issue_rdy); end
        checks++; if (tr_addr[0] !== 32'd4) begin errors++; $display("FAIL wst_addr got %h exp 4", tr_addr[0]); end
        checks++; if (tr_mask[0] !== 4'b1111) begin errors++; $display("FAIL wst_mask got %b exp 1111", tr_mask[0]); end
        checks++; if (we_cycles !== 1 || tr_we[0] !== 1'b1) begin errors++; $display("FAIL wst_we got %0d cycles exp 1", we_cycles); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wst_lat got %0d exp 2", lat); end
        checks++; if (rsp_cnt !== 1) begin errors++; $display("FAIL wst_pulse got %0d exp 1", rsp_cnt); end
        checks++; if (tr_rdy[1] !== 1'b0 || tr_rdy[2] !== 1'b1) begin errors++; $display("FAIL wst_ready_return got %b%b exp 01", tr_rdy[1], tr_rdy[2]); end
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wst_mem got %h exp deadbeef", mem[4]); end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wld_lat got %0d exp 3", lat); end
        checks++; if (got_rdata !== 32'hDEAD_BEEF || got_err !== 1'b0) begin errors++; $display("FAIL wld_data got %h err %b exp deadbeef err 0", got_rdata, got_err); end
        checks++; if (tr_mask[0] !== 4'd0 || we_cycles !== 0) begin errors++; $display("FAIL wld_nowrite got mask %b we %0d exp 0000 0", tr_mask[0], we_cycles); end
    endtask

    task automatic test_byte_extend;
        mem[0] = 32'h80FF_7F01;
        run_req(1'b0, 2'b00, 1'b0, 32'h2, 32'd0);
        checks++; if (got_rdata !== 32'hFFFF_FFFF || lat !== 3) begin errors++; $display("FAIL lb2_s got %h lat %0d exp ffffffff lat 3", got_rdata, lat); end
        run_req(1'b0, 2'b00, 1'b0, 32'h3, 32'd0);
        checks++; if (got_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb3_s got %h exp ffffff80", got_rdata); end
        run_req(1'b0, 2'b00, 1'b1, 32'h3, 32'd0);
        checks++; if (got_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lb3_u got %h exp 00000080", got_rdata); end
        run_req(1'b0, 2'b00, 1'b0, 32'h1, 32'd0);
        checks++; if (got_rdata !== 32'h0000_007F) begin errors++; $display("FAIL lb1_s got %h exp 0000007f", got_rdata); end
        run_req(1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFF_FFAB);
        checks++; if (tr_mask[0] !== 4'b0010) begin errors++; $display("FAIL sb_mask got %b exp 0010", tr_mask[0]); end
        checks++; if (tr_wdata[0] !== 32'h0000_AB00) begin errors++; $display("FAIL sb_wdata got %h exp 0000ab00", tr_wdata[0]); end
        checks++; if (mem[0] !== 32'h80FF_AB01) begin errors++; $display("FAIL sb_mem got %h exp 80ffab01", mem[0]); end
    endtask

    task automatic test_split_store;
        mem[1] = 32'd0; mem[2] = 32'd0;
        run_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h1122_3344);
        checks++; if (tr_addr[0] !== 32'd1 || tr_mask[0] !== 4'b1100) begin errors++; $display("FAIL ss_acc0 got addr %h mask %b exp 1 1100", tr_addr[0], tr_mask[0]); end
        checks++; if (tr_wdata[0][31:16] !== 16'h3344) begin errors++; $display("FAIL ss_wd0 got %h exp 3344", tr_wdata[0][31:16]); end
        checks++; if (tr_addr[1] !== 32'd2 || tr_mask[1] !== 4'b0011) begin errors++; $display("FAIL ss_acc1 got addr %h mask %b exp 2 0011", tr_addr[1], tr_mask[1]); end
        checks++; if (tr_wdata[1][15:0] !== 16'h1122) begin errors++; $display("FAIL ss_wd1 got %h exp 1122", tr_wdata[1][15:0]); end
        checks++; if (lat !== 3 || we_cycles !== 2) begin errors++; $display("FAIL ss_timing got lat %0d we %0d exp 3 2", lat, we_cycles); end
        checks++; if (mem[1] !== 32'h3344_0000 || mem[2] !== 32'h0000_1122) begin errors++; $display("FAIL ss_mem got %h %h exp 33440000 00001122", mem[1], mem[2]); end
        run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
        checks++; if (lat !== 4 || got_rdata !== 32'h1122_3344) begin errors++; $display("FAIL sl_word got %h lat %0d exp 11223344 lat 4", got_rdata, lat); end
    endtask

    task automatic test_split_half;
        mem[0] = 32'hAA00_0000; mem[1] = 32'h0000_00BB;
        run_req(1'b0, 2'b01, 1'b0, 32'h3, 32'd0);
        checks++; if (lat !== 4 || got_rdata !== 32'hFFFF_BBAA) begin errors++; $display("FAIL lh3_s got %h lat %0d exp ffffbbaa lat 4", got_rdata, lat); end
        run_req(1'b0, 2'b01, 1'b1, 32'h3, 32'd0);
        checks++; if (got_rdata !== 32'h0000_BBAA) begin errors++; $display("FAIL lh3_u got %h exp 0000bbaa", got_rdata); end
    endtask

    task automatic test_errors;
        mem[MEM_SIZE-1] = 32'd0;
        run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
        checks++; if (got_err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_ld got err %b lat %0d exp 1 lat 1", got_err, lat); end
        checks++; if (got_rdata !== 32'd0) begin errors++; $display("FAIL err_ld_rdata got %h exp 0", got_rdata); end
        run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF);
        checks++; if (got_err !== 1'b1 || we_cycles !== 0) begin errors++; $display("FAIL err_st got err %b we %0d exp 1 0", got_err, we_cycles); end
        checks++; if (mem[0] !== 32'hAA00_0000) begin errors++; $display("FAIL err_st_mem got %h exp aa000000", mem[0]); end
        run_req(1'b1, 2'b10, 1'b0, 32'(4*MEM_SIZE-2), 32'h1234_5678);
        checks++; if (got_err !== 1'b1 || lat !== 1 || we_cycles !== 0) begin errors++; $display("FAIL err_range got err %b lat %0d we %0d exp 1 1 0", got_err, lat, we_cycles); end
        checks++; if (mem[MEM_SIZE-1] !== 32'd0) begin errors++; $display("FAIL err_range_mem got %h exp 0", mem[MEM_SIZE-1]); end
        run_req(1'b1, 2'b10, 1'b0, 32'(4*(MEM_SIZE-1)), 32'hCAFE_F00D);
        checks++; if (got_err !== 1'b0 || lat !== 2) begin errors++; $display("FAIL last_word got err %b lat %0d exp 0 2", got_err, lat); end
        checks++; if (tr_addr[0] !== 32'(MEM_SIZE-1) || mem[MEM_SIZE-1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word_mem got addr %h data %h exp 3ff cafef00d", tr_addr[0], mem[MEM_SIZE-1]); end
    endtask

    task automatic test_back_to_back;
        logic        we_at   [7];
        logic [31:0] addr_at [7];
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_addr = 32'h24; req_wdata = 32'd2;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            we_at[c] = mem_we; addr_at[c] = mem_addr;
            if (c == 2) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        checks++; if (we_at[0] !== 1'b1 || addr_at[0] !== 32'd8) begin errors++; $display("FAIL b2b_first got we %b addr %h exp 1 8", we_at[0], addr_at[0]); end
        checks++; if (we_at[1] !== 1'b0 || we_at[2] !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b%b exp 00", we_at[1], we_at[2]); end
        checks++; if (we_at[3] !== 1'b1 || addr_at[3] !== 32'd9) begin errors++; $display("FAIL b2b_second got we %b addr %h exp 1 9", we_at[3], addr_at[3]); end
        checks++; if (mem[8] !== 32'd1 || mem[9] !== 32'd2) begin errors++; $display("FAIL b2b_mem got %h %h exp 1 2", mem[8], mem[9]); end
    endtask

    task automatic test_reset_mid;
        int seen;
        mem[0] = 32'd0; mem[1] = 32'h5555_5555;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h2; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(posedge clk);
        // Reset is sampled on the edge that would start ACC1
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_wmask !== 4'b1100) begin errors++; $display("FAIL rm_acc0 got we %b mask %b exp 1 1100", mem_we, mem_wmask); end
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_wmask !== 4'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_quiet got we %b mask %b vld %b exp 0 0000 0", mem_we, mem_wmask, rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset got %b exp 0", req_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after got %b exp 1", req_ready); end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_rsp got %0d exp 0", seen); end
        checks++; if (mem[0] !== 32'h3344_0000 || mem[1] !== 32'h5555_5555) begin errors++; $display("FAIL rm_mem got %h %h exp 33440000 55555555", mem[0], mem[1]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'd0;
        test_reset;
        test_word;
        test_byte_extend;
        test_split_store;
        test_split_half;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
